// File: rtl/atm_pkg.sv
// Shared constants and state encoding for the ATM balance
// transaction controller.
package atm_pkg;

    localparam logic [1:0] OP_QUERY = 2'b00;
    localparam logic [1:0] OP_DEP   = 2'b01;
    localparam logic [1:0] OP_WD    = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NSF = 2'b01;
    localparam logic [1:0] ST_OVF = 2'b10;
    localparam logic [1:0] ST_LIM = 2'b11;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the
// requester after last_i and wraps.
module atm_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         last_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [1:0]         idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (int'(last_i) + k) % NUM_REQ;
            if (en_i && !found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = 2'(j);
            end
        end
    end

endmodule

// File: rtl/atm_txn_arbiter.sv
// Shared-balance transaction controller: arbitrates requesters and
// executes one atomic balance operation per three cycles.
module atm_txn_arbiter
    import atm_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int BAL_W    = 8,
    parameter int AMT_W    = 4,
    parameter int WD_LIMIT = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [AMT_W*NUM_REQ-1:0] req_amt,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     session_start,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_id,
    output logic [1:0]               rsp_status,
    output logic [BAL_W-1:0]         balance,
    output logic [BAL_W-1:0]         wd_total,
    output logic                     busy,
    output logic [7:0]               txn_count
);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [1:0]         id_q, id_d;
    logic [1:0]         last_q, last_d;
    logic [BAL_W-1:0]   bal_q, bal_d;
    logic [BAL_W-1:0]   wd_q, wd_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [1:0]         st_q, st_d;

    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_idx;
    logic [BAL_W-1:0]   amt_ext;
    logic [BAL_W:0]     sum_dep;
    logic [BAL_W:0]     sum_wd;
    logic [1:0]         st_nxt;

    atm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i  (req_valid),
        .last_i (last_q),
        .en_i   (state_q == ARB),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    assign amt_ext = {{(BAL_W-AMT_W){1'b0}}, amt_q};
    assign sum_dep = {1'b0, bal_q} + {1'b0, amt_ext};
    assign sum_wd  = {1'b0, wd_q} + {1'b0, amt_ext};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        amt_d   = amt_q;
        id_d    = id_q;
        last_d  = last_q;
        bal_d   = bal_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        st_nxt  = ST_OK;
        unique case (state_q)
            ARB: begin
                if (|(req_valid & gnt)) begin
                    op_d    = req_op[2*gnt_idx +: 2];
                    amt_d   = req_amt[AMT_W*gnt_idx +: AMT_W];
                    id_d    = gnt_idx;
                    last_d  = gnt_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                unique case (op_q)
                    OP_QUERY: st_nxt = ST_OK;
                    OP_DEP: begin
                        if (sum_dep[BAL_W]) st_nxt = ST_OVF;
                        else bal_d = sum_dep[BAL_W-1:0];
                    end
                    OP_WD: begin
                        if (amt_ext > bal_q) begin
                            st_nxt = ST_NSF;
                        end else if (sum_wd > (BAL_W+1)'(WD_LIMIT)) begin
                            st_nxt = ST_LIM;
                        end else begin
                            bal_d = bal_q - amt_ext;
                            wd_d  = sum_wd[BAL_W-1:0];
                        end
                    end
                    OP_CLR: begin
                        bal_d = '0;
                        wd_d  = '0;
                    end
                endcase
                st_d = st_nxt;
                if (st_nxt == ST_OK) cnt_d = cnt_q + 8'd1;
                state_d = RESP;
            end
            RESP:    state_d = ARB;
            default: state_d = ARB;
        endcase
        // A new session overrides any withdrawal recorded this edge.
        if (session_start) wd_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            op_q    <= '0;
            amt_q   <= '0;
            id_q    <= '0;
            last_q  <= 2'(NUM_REQ-1);
            bal_q   <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            bal_q   <= bal_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
        end
    end

    assign req_ready  = gnt;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_status = st_q;
    assign balance    = bal_q;
    assign wd_total   = wd_q;
    assign busy       = (state_q != ARB);
    assign txn_count  = cnt_q;

endmodule
